// File: rtl/pll_loop_ctrl.sv
// -----------------------------------------------------------------------------
// pll_loop_ctrl
//
// Loop-filter controller that sits after the PLL phase detector. It turns the
// detector's forwarding/slowing requests into a saturating DCO tuning word.
// It sequences three phases:
//   - acquisition: coarse steps of ACQ_STEP
//   - tracking: unit steps
//   - lock: declared after LOCK_CNT consecutive quiet windows
//
// Optional feature macro: PLL_CTRL_HOLDOVER_EN
//   When defined, the holdover_i port exists and the HOLD state can be entered
//   from TRACK or LOCKED. In HOLD the tuning word is frozen.
//   When undefined, the port is absent and HOLD is unreachable.
//
// Ports
//   clk_i        in   1       system clock, rising edge
//   reset_i      in   1       synchronous active-low reset
//   enable_i     in   1       loop enable; low forces IDLE from any state
//   forwarding_i in   1       phase detector "speed up" request
//   slowing_i    in   1       phase detector "slow down" request
//   holdover_i   in   1       freeze request (PLL_CTRL_HOLDOVER_EN only)
//   tune_o       out  TUNE_W  registered DCO tuning word
//   locked_o     out  1       registered lock indicator
//   state_o      out  3       FSM state: IDLE=0 ACQUIRE=1 TRACK=2 LOCKED=3 HOLD=4
// -----------------------------------------------------------------------------
module pll_loop_ctrl #(
  parameter int TUNE_W    = 12,
  parameter int TUNE_INIT = 2048,
  parameter int ACQ_STEP  = 16,
  parameter int REV_CNT   = 4,
  parameter int LOCK_WIN  = 256,
  parameter int LOCK_TOL  = 8,
  parameter int LOCK_CNT  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              forwarding_i,
  input  logic              slowing_i,
`ifdef PLL_CTRL_HOLDOVER_EN
  input  logic              holdover_i,
`endif
  output logic [TUNE_W-1:0] tune_o,
  output logic              locked_o,
  output logic [2:0]        state_o
);

  localparam int REV_W  = $clog2(REV_CNT + 1);
  localparam int WIN_W  = $clog2(LOCK_WIN);
  // One bit wider than the window index: a window can hold LOCK_WIN corrections.
  localparam int CORR_W = $clog2(LOCK_WIN + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [TUNE_W-1:0] TUNE_INIT_W = TUNE_W'(TUNE_INIT);
  localparam logic [TUNE_W-1:0] ACQ_STEP_W  = TUNE_W'(ACQ_STEP);
  localparam logic [TUNE_W-1:0] TUNE_ONE    = TUNE_W'(1);
  localparam logic [REV_W-1:0]  REV_LAST    = REV_W'(REV_CNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(LOCK_WIN - 1);
  localparam logic [CORR_W-1:0] LOCK_TOL_W  = CORR_W'(LOCK_TOL);
  localparam logic [GOOD_W-1:0] LOCK_CNT_W  = GOOD_W'(LOCK_CNT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    TRACK   = 3'd2,
    LOCKED  = 3'd3,
    HOLD    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TUNE_W-1:0]   tune_q, tune_d;
  logic                locked_q, locked_d;
  logic                dir_valid_q, dir_valid_d;
  logic                dir_up_q, dir_up_d;
  logic [REV_W-1:0]    rev_cnt_q, rev_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [CORR_W-1:0]   corr_cnt_q, corr_cnt_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;

  // Without the holdover feature the request is tied off, so HOLD can never
  // be entered.
  logic hold_req;
`ifdef PLL_CTRL_HOLDOVER_EN
  assign hold_req = holdover_i;
`else
  assign hold_req = 1'b0;
`endif

  // Both requests high, or both low, means no correction.
  logic corr_up, corr_dn, corr_any;
  assign corr_up  = forwarding_i & ~slowing_i;
  assign corr_dn  = slowing_i & ~forwarding_i;
  assign corr_any = corr_up | corr_dn;

  // Saturating tuning step. The extra sum bit detects overflow past the top
  // code. Underflow is caught by comparing against the step before subtracting.
  logic [TUNE_W-1:0] step_sel;
  logic [TUNE_W-1:0] tune_stepped;
  logic [TUNE_W:0]   up_sum;

  always_comb begin
    step_sel     = (state_q == ACQUIRE) ? ACQ_STEP_W : TUNE_ONE;
    up_sum       = {1'b0, tune_q} + {1'b0, step_sel};
    tune_stepped = tune_q;
    if (corr_up) begin
      tune_stepped = up_sum[TUNE_W] ? {TUNE_W{1'b1}} : up_sum[TUNE_W-1:0];
    end else if (corr_dn) begin
      tune_stepped = (tune_q < step_sel) ? '0 : (tune_q - step_sel);
    end
  end

  // Window bookkeeping. The correction seen in the window's last cycle is
  // folded into the total before the window is judged.
  logic              win_last;
  logic              win_good;
  logic [CORR_W-1:0] corr_total;
  logic [GOOD_W-1:0] good_inc;

  always_comb begin
    win_last   = (win_cnt_q == WIN_LAST);
    corr_total = corr_cnt_q + {{(CORR_W-1){1'b0}}, corr_any};
    win_good   = (corr_total <= LOCK_TOL_W);
    good_inc   = (good_cnt_q == LOCK_CNT_W) ? good_cnt_q : (good_cnt_q + GOOD_W'(1));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    tune_d      = tune_q;
    locked_d    = locked_q;
    dir_valid_d = dir_valid_q;
    dir_up_d    = dir_up_q;
    rev_cnt_d   = rev_cnt_q;
    win_cnt_d   = win_cnt_q;
    corr_cnt_d  = corr_cnt_q;
    good_cnt_d  = good_cnt_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d     = ACQUIRE;
          tune_d      = TUNE_INIT_W;
          dir_valid_d = 1'b0;
          dir_up_d    = 1'b0;
          rev_cnt_d   = '0;
        end
      end

      ACQUIRE: begin
        if (!enable_i) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else begin
          tune_d = tune_stepped;
          if (corr_any) begin
            dir_valid_d = 1'b1;
            dir_up_d    = corr_up;
            // The first correction only primes the direction register; it
            // has nothing to reverse against.
            if (dir_valid_q && (dir_up_q != corr_up)) begin
              rev_cnt_d = rev_cnt_q + REV_W'(1);
              if (rev_cnt_q == REV_LAST) begin
                state_d    = TRACK;
                win_cnt_d  = '0;
                corr_cnt_d = '0;
                good_cnt_d = '0;
              end
            end
          end
        end
      end

      TRACK, LOCKED: begin
        if (!enable_i) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (hold_req) begin
          // locked_q is left untouched, so lock status survives holdover
          // only when it was already asserted.
          state_d = HOLD;
        end else begin
          tune_d = tune_stepped;
          if (win_last) begin
            win_cnt_d  = '0;
            corr_cnt_d = '0;
            if (win_good) begin
              good_cnt_d = good_inc;
              if ((state_q == TRACK) && (good_inc == LOCK_CNT_W)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              good_cnt_d = '0;
              state_d    = TRACK;
              locked_d   = 1'b0;
            end
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            corr_cnt_d = corr_total;
          end
        end
      end

      HOLD: begin
        if (!enable_i) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (!hold_req) begin
          state_d    = TRACK;
          locked_d   = 1'b0;
          win_cnt_d  = '0;
          corr_cnt_d = '0;
          good_cnt_d = '0;
        end
      end

      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      tune_q      <= TUNE_INIT_W;
      locked_q    <= 1'b0;
      dir_valid_q <= 1'b0;
      dir_up_q    <= 1'b0;
      rev_cnt_q   <= '0;
      win_cnt_q   <= '0;
      corr_cnt_q  <= '0;
      good_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tune_q      <= tune_d;
      locked_q    <= locked_d;
      dir_valid_q <= dir_valid_d;
      dir_up_q    <= dir_up_d;
      rev_cnt_q   <= rev_cnt_d;
      win_cnt_q   <= win_cnt_d;
      corr_cnt_q  <= corr_cnt_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  assign tune_o   = tune_q;
  assign locked_o = locked_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_loop_ctrl
//
// Testbench for pll_loop_ctrl. It applies stimulus in three phases:
//   - a table of vectors covering reset, coarse acquisition and the reversal
//     count into tracking
//   - hand-written sequences for saturation, the lock window boundaries and
//     holdover (when PLL_CTRL_HOLDOVER_EN is defined)
//   - randomized runs compared every cycle against a behavioural model
//
// The model judges each window from a queue of per-cycle correction flags.
// -----------------------------------------------------------------------------
module tb_pll_loop_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        forwarding_i = 1'b0;
  logic        slowing_i = 1'b0;
  logic        holdover_i = 1'b0;
  logic [11:0] tune_o;
  logic        locked_o;
  logic [2:0]  state_o;

  always #5 clk_i = ~clk_i;

  pll_loop_ctrl dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .forwarding_i (forwarding_i),
    .slowing_i    (slowing_i),
`ifdef PLL_CTRL_HOLDOVER_EN
    .holdover_i   (holdover_i),
`endif
    .tune_o       (tune_o),
    .locked_o     (locked_o),
    .state_o      (state_o)
  );

`ifdef PLL_CTRL_HOLDOVER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------- reference model
  int m_tune;
  int m_state;
  int m_last_dir;
  int m_revs;
  int m_good;
  bit m_locked;
  bit m_have_dir;
  int win_hist[$];

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  task automatic model_step(input bit rn, input bit en, input bit f, input bit s, input bit ho);
    int dir;
    int n;
    dir = (f && !s) ? 1 : ((s && !f) ? -1 : 0);
    if (!rn) begin
      m_tune = 2048; m_locked = 0; m_state = 0;
      m_have_dir = 0; m_last_dir = 0; m_revs = 0; m_good = 0;
      win_hist.delete();
      return;
    end
    if (m_state != 0 && !en) begin
      m_state = 0; m_locked = 0;
      return;
    end
    case (m_state)
      0: begin
        if (en) begin
          m_state = 1; m_tune = 2048; m_have_dir = 0; m_revs = 0;
        end
      end
      1: begin
        m_tune = clamp(m_tune + 16 * dir);
        if (dir != 0) begin
          if (m_have_dir && dir != m_last_dir) m_revs++;
          m_have_dir = 1;
          m_last_dir = dir;
          if (m_revs >= 4) begin
            m_state = 2; m_good = 0; win_hist.delete();
          end
        end
      end
      2, 3: begin
        if (HOLD_EN && ho) begin
          m_state = 4;
          return;
        end
        m_tune = clamp(m_tune + dir);
        win_hist.push_back((dir != 0) ? 1 : 0);
        if (win_hist.size() == 256) begin
          n = 0;
          foreach (win_hist[k]) n += win_hist[k];
          win_hist.delete();
          if (n <= 8) begin
            m_good++;
            if (m_state == 2 && m_good >= 4) begin
              m_state = 3; m_locked = 1;
            end
          end else begin
            m_good = 0;
            m_state = 2; m_locked = 0;
          end
        end
      end
      4: begin
        if (!ho) begin
          m_state = 2; m_locked = 0; m_good = 0; win_hist.delete();
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Inputs change on the falling edge; outputs are sampled 1 unit after the
  // rising edge. The model advances once per rising edge.
  task automatic cycle(input bit rn, input bit en, input bit f, input bit s, input bit ho);
    @(negedge clk_i);
    reset_i      = rn;
    enable_i     = en;
    forwarding_i = f;
    slowing_i    = s;
    holdover_i   = ho;
    @(posedge clk_i);
    #1;
    model_step(rn, en, f, s, holdover_i);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0);
  endtask

  task automatic fwd(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 1, 0, 0);
  endtask

  task automatic slw(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 1, 0);
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input int et, input bit el, input int es);
    n_vec++;
    if (tune_o !== 12'(et) || locked_o !== el || state_o !== 3'(es)) begin
      n_fail++;
      $display("FAIL %s: got tune=%0d locked=%0b state=%0d, want tune=%0d locked=%0b state=%0d",
               name, tune_o, locked_o, state_o, et, el, es);
    end
  endtask

  // Reset, enable, then F,S,F,S,F: four reversals land the FSM in TRACK at 2064.
  task automatic to_track();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    fwd(1); slw(1); fwd(1); slw(1); fwd(1);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    bit rn;
    bit en;
    bit f;
    bit s;
    int tune;
    bit locked;
    int state;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit rn, input bit en, input bit f, input bit s,
                                  input int tune, input bit locked, input int state);
    vec_t v;
    v.rn = rn; v.en = en; v.f = f; v.s = s;
    v.tune = tune; v.locked = locked; v.state = state;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------- watchdog
  initial begin
    #10000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main test
  initial begin
    bit rn, en, f, s;
    int r, thr, t;

    // Reset held while forwarding toggles.
    for (int i = 0; i < 5; i++) add_vec(0, 0, 1'(i % 2), 0, 2048, 0, 0);
    // IDLE holds; enable loads TUNE_INIT and ignores that cycle's correction.
    add_vec(1, 0, 1, 0, 2048, 0, 0);
    add_vec(1, 1, 1, 0, 2048, 0, 1);
    // Ten coarse UP steps in ACQUIRE.
    for (int k = 0; k < 10; k++) add_vec(1, 1, 1, 0, 2064 + 16 * k, 0, 1);
    // Fresh acquisition: four reversals from TUNE_INIT, then unit steps in TRACK.
    add_vec(0, 1, 0, 0, 2048, 0, 0);
    add_vec(1, 1, 0, 0, 2048, 0, 1);
    add_vec(1, 1, 1, 1, 2048, 0, 1);
    add_vec(1, 1, 1, 0, 2064, 0, 1);
    add_vec(1, 1, 0, 1, 2048, 0, 1);
    add_vec(1, 1, 1, 0, 2064, 0, 1);
    add_vec(1, 1, 0, 1, 2048, 0, 1);
    add_vec(1, 1, 1, 0, 2064, 0, 2);
    add_vec(1, 1, 1, 0, 2065, 0, 2);
    add_vec(1, 1, 0, 1, 2064, 0, 2);
    add_vec(1, 1, 1, 1, 2064, 0, 2);
    // Enable drop: IDLE next cycle with tune held; re-enable reloads.
    add_vec(1, 0, 1, 0, 2064, 0, 0);
    add_vec(1, 0, 0, 1, 2064, 0, 0);
    add_vec(1, 1, 0, 0, 2048, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rn, vecs[i].en, vecs[i].f, vecs[i].s, 0);
      check($sformatf("vec%0d", i), vecs[i].tune, vecs[i].locked, vecs[i].state);
    end

    // Floor saturation in ACQUIRE, then enable drop mid-ACQUIRE.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    slw(127);
    check("acq_down_127", 16, 0, 1);
    slw(1);
    check("acq_floor", 0, 0, 1);
    slw(3);
    check("acq_floor_hold", 0, 0, 1);
    cycle(1, 0, 0, 1, 0);
    check("acq_disable", 0, 0, 0);

    // Ceiling saturation in ACQUIRE.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    fwd(127);
    check("acq_up_127", 4080, 0, 1);
    fwd(1);
    check("acq_ceiling", 4095, 0, 1);
    fwd(2);
    check("acq_ceiling_hold", 4095, 0, 1);

    // Lock after exactly four quiet windows, then the LOCK_TOL boundary.
    to_track();
    check("track_entry", 2064, 0, 2);
    quiet(1023);
    check("lock_pre", 2064, 0, 2);
    quiet(1);
    check("lock_edge", 2064, 1, 3);
    fwd(8); quiet(247);
    check("win8_pre", 2072, 1, 3);
    quiet(1);
    check("win8_end", 2072, 1, 3);
    // Ninth correction arrives on the window's last cycle and still counts.
    fwd(8); quiet(247);
    check("win9_pre", 2080, 1, 3);
    fwd(1);
    check("win9_end", 2081, 0, 2);

`ifdef PLL_CTRL_HOLDOVER_EN
    to_track();
    quiet(1024);
    check("ho_locked", 2064, 1, 3);
    cycle(1, 1, 1, 0, 1);
    check("ho_enter", 2064, 1, 4);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 1);
    check("ho_frozen", 2064, 1, 4);
    cycle(1, 1, 0, 0, 0);
    check("ho_release", 2064, 0, 2);
`endif

    // Randomized runs against the model, with increasing correction density.
    for (int seg = 0; seg < 4; seg++) begin
      thr = (seg == 0) ? 5 : (seg == 1) ? 25 : (seg == 2) ? 35 : 60;
      cycle(0, 0, 0, 0, 0);
      check("rand_reset", m_tune, m_locked, m_state);
      for (int c = 0; c < 1540; c++) begin
        t  = (c < 40) ? 800 : thr;
        r  = int'($urandom_range(0, 999));
        rn = ($urandom_range(0, 2999) != 0);
        en = ($urandom_range(0, 1499) != 0);
        if (r < t) begin
          f = 1'($urandom_range(0, 1));
          s = !f;
        end else if (r < t + 10) begin
          f = 1; s = 1;
        end else begin
          f = 0; s = 0;
        end
        cycle(rn, en, f, s, 0);
        check("rand", m_tune, m_locked, m_state);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
